// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM encoding and width constants for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int XLEN   = 32;
    localparam int RD_W   = 5;
    localparam int LANES  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // funct3[1:0] encodes access size for both loads and stores
    function automatic logic [LANES-1:0] lane_mask(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   lane_mask = 4'b0001 << offset;
            2'b01:   lane_mask = 4'b0011 << offset;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// rtl/lsu_mem_if_if.sv - request, data-memory and response signals of the load/store unit
interface lsu_mem_if_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_wr;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [RD_W-1:0] req_rd;

    logic [XLEN-1:0]  mem_address;
    logic [XLEN-1:0]  mem_datain;
    logic             mem_wen;
    logic             mem_ren;
    logic [LANES-1:0] mem_byte_selector;
    logic [XLEN-1:0]  mem_dataout;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic [RD_W-1:0] resp_rd;
    logic            resp_err;

    modport master (
        input  req_valid, req_wr, req_funct3, req_addr, req_wdata, req_rd, mem_dataout,
        output req_ready, mem_address, mem_datain, mem_wen, mem_ren, mem_byte_selector,
        output resp_valid, resp_rdata, resp_rd, resp_err
    );

    modport slave (
        output req_valid, req_wr, req_funct3, req_addr, req_wdata, req_rd, mem_dataout,
        input  req_ready, mem_address, mem_datain, mem_wen, mem_ren, mem_byte_selector,
        input  resp_valid, resp_rdata, resp_rd, resp_err
    );

endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts the addressed lane of a memory word and sign/zero-extends it
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word >> {offset, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - single-outstanding load/store unit driving a word-addressed data memory
module lsu_mem_if #(
    parameter int ADDR_WORDS  = 1024,
    parameter int MEM_LATENCY = 1
) (
    input logic          clk,
    input logic          rst_n,
    lsu_mem_if_if.master bus
);
    import lsu_pkg::*;

    localparam logic [XLEN-1:0] WORDS_LIMIT = 32'(ADDR_WORDS);
    localparam logic [1:0]      LAT_INIT    = 2'(MEM_LATENCY);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  datain_q, datain_d;
    logic [LANES-1:0] sel_q, sel_d;
    logic             wen_q, wen_d;
    logic             ren_q, ren_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_rdata_q, resp_rdata_d;
    logic [RD_W-1:0]  resp_rd_q, resp_rd_d;
    logic             resp_err_q, resp_err_d;

    logic             legal, misaligned, out_of_range, req_err;
    logic [XLEN-1:0]  word_idx, store_rep, load_ext;

    lsu_load_align u_align (
        .word   (bus.mem_dataout),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_ext)
    );

    always_comb begin
        case (bus.req_funct3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !bus.req_wr;
            default:          legal = 1'b0;
        endcase
        misaligned   = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                       (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
        word_idx     = {2'b00, bus.req_addr[31:2]};
        out_of_range = word_idx >= WORDS_LIMIT;
        req_err      = !legal || misaligned || out_of_range;
        case (bus.req_funct3[1:0])
            2'b00:   store_rep = {4{bus.req_wdata[7:0]}};
            2'b01:   store_rep = {2{bus.req_wdata[15:0]}};
            default: store_rep = bus.req_wdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        f3_d         = f3_q;
        off_d        = off_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        datain_d     = datain_q;
        sel_d        = sel_q;
        wen_d        = 1'b0;
        ren_d        = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_rd_d    = '0;
        resp_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d  = bus.req_wr;
                    f3_d  = bus.req_funct3;
                    off_d = bus.req_addr[1:0];
                    rd_d  = bus.req_rd;
                    // Rejected requests answer immediately and leave the memory bus untouched
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rd_d    = bus.req_rd;
                    end else begin
                        state_d  = ST_ACCESS;
                        addr_d   = word_idx;
                        sel_d    = lane_mask(bus.req_funct3, bus.req_addr[1:0]);
                        datain_d = bus.req_wr ? store_rep : '0;
                        wen_d    = bus.req_wr;
                        ren_d    = !bus.req_wr;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
                cnt_d   = LAT_INIT;
            end
            ST_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rd_d    = rd_q;
                    resp_rdata_d = wr_q ? '0 : load_ext;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            addr_q       <= '0;
            datain_q     <= '0;
            sel_q        <= '0;
            wen_q        <= 1'b0;
            ren_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            datain_q     <= datain_d;
            sel_q        <= sel_d;
            wen_q        <= wen_d;
            ren_q        <= ren_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready         = (state_q == ST_IDLE);
    assign bus.mem_address       = addr_q;
    assign bus.mem_datain        = datain_q;
    assign bus.mem_wen           = wen_q;
    assign bus.mem_ren           = ren_q;
    assign bus.mem_byte_selector = sel_q;
    assign bus.resp_valid        = resp_valid_q;
    assign bus.resp_rdata        = resp_rdata_q;
    assign bus.resp_rd           = resp_rd_q;
    assign bus.resp_err          = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - self-checking bench for lsu_mem_if against a byte-array reference model
module tb_lsu_mem_if;
    import lsu_pkg::*;

    localparam int ADDR_WORDS  = 1024;
    localparam int MEM_LATENCY = 1;

    typedef struct packed {
        logic [1:0]  nstrobe;
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] din;
        logic [4:0]  lat;
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rd;
        logic        ready_bad;
    } txn_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  sel;
        logic [31:0] din;
    } dir_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   resp_count = 0;

    logic [31:0] tb_mem    [0:ADDR_WORDS-1];
    logic [31:0] rd_pipe   [0:MEM_LATENCY-1];
    logic [7:0]  ref_bytes [0:4*ADDR_WORDS-1];
    dir_t        dir_tbl   [11];

    always #5 clk = ~clk;

    lsu_mem_if_if bus();

    lsu_mem_if #(.ADDR_WORDS(ADDR_WORDS), .MEM_LATENCY(MEM_LATENCY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_dataout = rd_pipe[MEM_LATENCY-1];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ADDR_WORDS; i++) tb_mem[i] <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) rd_pipe[i] <= '0;
        end else begin
            if (bus.mem_wen && bus.mem_address < 32'(ADDR_WORDS))
                for (int i = 0; i < 4; i++)
                    if (bus.mem_byte_selector[i])
                        tb_mem[bus.mem_address[9:0]][8*i +: 8] <= bus.mem_datain[8*i +: 8];
            for (int i = MEM_LATENCY - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
            if (bus.mem_ren && bus.mem_address < 32'(ADDR_WORDS))
                rd_pipe[0] <= tb_mem[bus.mem_address[9:0]];
        end
    end

    always @(negedge clk) if (bus.resp_valid === 1'b1) resp_count <= resp_count + 1;

    task automatic model_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, output txn_t e);
        int          size;
        bit          illegal, mis, oor;
        logic [31:0] v;
        logic [3:0]  sel;
        size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis     = (addr % size) != 0;
        oor     = (addr / 4) >= ADDR_WORDS;
        e       = '0;
        e.rd    = rd;
        if (illegal || mis || oor) begin
            e.err = 1'b1;
            e.lat = 5'd0;
        end else begin
            e.nstrobe = 2'd1;
            e.wen     = wr;
            e.ren     = !wr;
            e.addr    = addr / 4;
            e.lat     = 5'(MEM_LATENCY + 2);
            sel       = '0;
            for (int j = 0; j < size; j++) sel[(addr % 4) + j] = 1'b1;
            e.sel = sel;
            if (wr) begin
                for (int i = 0; i < 4; i++) e.din[8*i +: 8] = wdata[8*(i % size) +: 8];
                for (int j = 0; j < size; j++) ref_bytes[addr + j] = wdata[8*j +: 8];
            end else begin
                v = '0;
                for (int j = 0; j < size; j++) v = v | (32'(ref_bytes[addr + j]) << (8*j));
                if (!f3[2] && size < 4 && v[8*size - 1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
                e.rdata = v;
            end
        end
    endtask

    task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input bit hold, output txn_t o);
        o     = '0;
        o.lat = 5'h1f;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        for (int w = 0; w < 20 && bus.req_ready !== 1'b1; w++) @(negedge clk);
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_rd    = 5'($urandom);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.mem_wen || bus.mem_ren) begin
                if (o.nstrobe == 2'd0) begin
                    o.addr = bus.mem_address;
                    o.sel  = bus.mem_byte_selector;
                    o.din  = bus.mem_datain;
                end
                if (o.nstrobe != 2'd3) o.nstrobe = o.nstrobe + 2'd1;
                o.wen = o.wen | bus.mem_wen;
                o.ren = o.ren | bus.mem_ren;
            end
            if (bus.req_ready !== 1'b0) o.ready_bad = 1'b1;
            if (bus.resp_valid === 1'b1) begin
                o.lat   = 5'(k);
                o.rdata = bus.resp_rdata;
                o.err   = bus.resp_err;
                o.rd    = bus.resp_rd;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
        end
        n_checks++;
        if ({bus.mem_wen, bus.mem_ren} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 00", {bus.mem_wen, bus.mem_ren});
        end
        n_checks++;
        if ({bus.mem_address, bus.mem_datain, bus.mem_byte_selector} !== 68'd0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h expected 0", {bus.mem_address, bus.mem_datain, bus.mem_byte_selector});
        end
        n_checks++;
        if ({bus.resp_valid, bus.resp_rdata, bus.resp_rd, bus.resp_err} !== 39'd0) begin
            n_fail++; $display("FAIL reset_resp: got %h expected 0", {bus.resp_valid, bus.resp_rdata, bus.resp_rd, bus.resp_err});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4*ADDR_WORDS; i++) ref_bytes[i] = '0;
    endtask

    task automatic test_directed();
        txn_t o, e;
        dir_tbl = '{
            '{1'b1, F3_W,  32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF},
            '{1'b0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0},
            '{1'b1, F3_B,  32'h13,   32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5},
            '{1'b0, F3_B,  32'h13,   32'h0,        32'hFFFFFFA5, 1'b0, 4'b1000, 32'h0},
            '{1'b0, F3_BU, 32'h13,   32'h0,        32'h000000A5, 1'b0, 4'b1000, 32'h0},
            '{1'b1, F3_W,  32'h0,    32'h80017FFF, 32'h0,        1'b0, 4'b1111, 32'h80017FFF},
            '{1'b0, F3_H,  32'h0,    32'h0,        32'h00007FFF, 1'b0, 4'b0011, 32'h0},
            '{1'b0, F3_H,  32'h2,    32'h0,        32'hFFFF8001, 1'b0, 4'b1100, 32'h0},
            '{1'b0, F3_HU, 32'h2,    32'h0,        32'h00008001, 1'b0, 4'b1100, 32'h0},
            '{1'b0, F3_W,  32'h2,    32'h0,        32'h0,        1'b1, 4'b0000, 32'h0},
            '{1'b1, F3_W,  32'h1000, 32'h12345678, 32'h0,        1'b1, 4'b0000, 32'h0}
        };
        for (int i = 0; i < 11; i++) begin
            run_txn(dir_tbl[i].wr, dir_tbl[i].f3, dir_tbl[i].addr, dir_tbl[i].wdata, 5'(i + 1), 1'b0, o);
            model_txn(dir_tbl[i].wr, dir_tbl[i].f3, dir_tbl[i].addr, dir_tbl[i].wdata, 5'(i + 1), e);
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL directed_%0d_model: got %h expected %h", i, o, e);
            end
            n_checks++;
            if ({o.rdata, o.err, o.sel, o.din} !== {dir_tbl[i].rdata, dir_tbl[i].err, dir_tbl[i].sel, dir_tbl[i].din}) begin
                n_fail++; $display("FAIL directed_%0d_const: got rdata=%h err=%b sel=%b din=%h expected rdata=%h err=%b sel=%b din=%h",
                    i, o.rdata, o.err, o.sel, o.din, dir_tbl[i].rdata, dir_tbl[i].err, dir_tbl[i].sel, dir_tbl[i].din);
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t        o, e;
        int          start;
        logic [31:0] wd;
        logic        wr_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3_t [4] = '{F3_W, F3_H, F3_H, F3_W};
        logic [31:0] ad_t [4] = '{32'h20, 32'h21, 32'h22, 32'h20};
        @(negedge clk);
        start = resp_count;
        for (int i = 0; i < 4; i++) begin
            wd = $urandom;
            run_txn(wr_t[i], f3_t[i], ad_t[i], wd, 5'(10 + i), 1'b1, o);
            model_txn(wr_t[i], f3_t[i], ad_t[i], wd, 5'(10 + i), e);
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL b2b_%0d: got %h expected %h", i, o, e);
            end
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_count - start !== 4) begin
            n_fail++; $display("FAIL b2b_resp_count: got %0d expected 4", resp_count - start);
        end
    endtask

    task automatic test_random();
        txn_t        o, e;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic [4:0]  rd;
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 9))
                0:       addr = 32'(4*ADDR_WORDS - 8) + 32'($urandom_range(0, 15));
                1:       addr = $urandom;
                default: addr = 32'($urandom_range(0, 63));
            endcase
            run_txn(wr, f3, addr, wd, rd, 1'b0, o);
            model_txn(wr, f3, addr, wd, rd, e);
            n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL random_%0d wr=%b f3=%0d addr=%h: got %h expected %h", i, wr, f3, addr, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t o, e;
        int   start;
        @(negedge clk);
        start = resp_count;
        bus.req_valid  = 1'b1;
        bus.req_wr     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        bus.req_rd     = 5'd7;
        for (int w = 0; w < 20 && bus.req_ready !== 1'b1; w++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_wen, bus.mem_ren, bus.resp_valid, bus.req_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL midreset_outputs: got wen/ren/resp/ready=%b expected 0001",
                {bus.mem_wen, bus.mem_ren, bus.resp_valid, bus.req_ready});
        end
        n_checks++;
        if ({bus.mem_address, bus.mem_byte_selector} !== 36'd0) begin
            n_fail++; $display("FAIL midreset_mem_bus: got %h expected 0", {bus.mem_address, bus.mem_byte_selector});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4*ADDR_WORDS; i++) ref_bytes[i] = '0;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (resp_count !== start) begin
            n_fail++; $display("FAIL midreset_stale_resp: got %0d responses expected 0", resp_count - start);
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_ready: got %b expected 1", bus.req_ready);
        end
        run_txn(1'b0, F3_W, 32'h10, 32'h0, 5'd9, 1'b0, o);
        model_txn(1'b0, F3_W, 32'h10, 32'h0, 5'd9, e);
        n_checks++;
        if (o !== e) begin
            n_fail++; $display("FAIL midreset_after: got %h expected %h", o, e);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        #1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
